// File: rtl/haar_lift_stage_if.sv
// -----------------------------------------------------------------------------
// haar_lift_stage_if
// Streaming bus of the Haar lifting stage.
//   Input side : mode, in_valid, in_ready, in_a, in_b, in_last
//   Output side: out_valid, out_ready, out_x, out_y, out_last, out_count
// Modports:
//   master - the environment: drives input beats and out_ready
//   slave  - the lifting stage: accepts beats and produces results
// -----------------------------------------------------------------------------
interface haar_lift_stage_if #(
  parameter int W     = 16,
  parameter int CNT_W = 12
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_x;
  logic [W-1:0]     out_y;
  logic             out_last;
  logic [CNT_W-1:0] out_count;

  modport master (
    output mode, in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_last, out_count
  );

  modport slave (
    input  mode, in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_x, out_y, out_last, out_count
  );
endinterface

// File: rtl/haar_lift_stage.sv
// -----------------------------------------------------------------------------
// haar_lift_stage
// Bidirectional Haar lifting stage, 2-stage valid/ready pipeline.
//   mode=0 (inverse): (h, sign-magnitude d) -> pixel pair (x, y)
//   mode=1 (forward): pixel pair (x, y)     -> (h, sign-magnitude d)
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset
//   bus      - streaming bus (slave modport), see haar_lift_stage_if
//   ovf      - sticky flag: a wrap or clamp happened on a transferred beat
//   ovf_clr  - synchronous clear of ovf (a simultaneous set wins)
// SAT=0 keeps modulo-2^W behaviour; SAT=1 works in W+1 bits and clamps.
// -----------------------------------------------------------------------------
module haar_lift_stage #(
  parameter int W     = 16,
  parameter bit SAT   = 1'b0,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  haar_lift_stage_if.slave bus,
  output logic             ovf,
  input  logic             ovf_clr
);

  logic                    s1_adv, s2_adv, out_fire;
  logic                    vld_p1, mode_p1, last_p1;
  logic [W-1:0]            a_p1, b_p1;
  logic                    vld_p2, last_p2, ovf_p2;
  logic [W-1:0]            x_p2, y_p2;
  logic [CNT_W-1:0]        cnt;

  logic [W-1:0]            op_b;
  logic [W:0]              sum;
  logic signed [W:0]       diff;
  logic [W:0]              inv_s, inv_d, fwd_h;
  logic [W-1:0]            fwd_m;
  logic [W-1:0]            x_c, y_c;
  logic                    ovf_c;

  // Halved inverse sum, returned as {ovf, value}. With clamping the W+1-bit
  // sum always fits after the shift; in modulo mode the carry is lost first.
  function automatic logic [W:0] half_sum(input logic [W:0] s);
    if (SAT) half_sum = {1'b0, s[W:1]};
    else     half_sum = {s[W], 1'b0, s[W-1:1]};
  endfunction

  // Halved inverse difference, returned as {ovf, value}. A borrow either
  // clamps to zero or wraps before the logical shift.
  function automatic logic [W:0] half_diff(input logic signed [W:0] d);
    if (SAT) half_diff = d[W] ? {1'b1, {W{1'b0}}} : {1'b0, 1'b0, d[W-1:1]};
    else     half_diff = {d[W], 1'b0, d[W-1:1]};
  endfunction

  // Forward approximation h = x+y as {ovf, value}: wrap or clamp to all-ones.
  function automatic logic [W:0] clamp_h(input logic [W:0] s);
    if (s[W]) clamp_h = SAT ? {1'b1, {W{1'b1}}} : {1'b1, s[W-1:0]};
    else      clamp_h = {1'b0, s[W-1:0]};
  endfunction

  // Detail magnitude reduced to W-1 bits, returned as {ovf, magnitude}.
  function automatic logic [W-1:0] clamp_mag(input logic [W-1:0] mag);
    if (mag[W-1]) clamp_mag = SAT ? {1'b1, {(W-1){1'b1}}} : {1'b1, mag[W-2:0]};
    else          clamp_mag = {1'b0, mag[W-2:0]};
  endfunction

  assign s2_adv       = ~vld_p2 | bus.out_ready;
  assign s1_adv       = ~vld_p1 | s2_adv;
  assign out_fire     = vld_p2 & bus.out_ready;
  assign bus.in_ready = s1_adv;

  // ---- S0 -> S1: capture the raw beat ----
  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) begin
      a_p1    <= bus.in_a;
      b_p1    <= bus.in_b;
      mode_p1 <= bus.mode;
      last_p1 <= bus.in_last;
    end
  end

  // ---- S1 -> S2: lifting arithmetic ----
  // One adder and one subtractor serve both directions: inverse uses the
  // detail magnitude as second operand, forward uses the raw pixel y.
  always_comb begin
    op_b  = mode_p1 ? b_p1 : {1'b0, b_p1[W-2:0]};
    sum   = {1'b0, a_p1} + {1'b0, op_b};
    diff  = $signed({1'b0, a_p1}) - $signed({1'b0, op_b});
    inv_s = half_sum(sum);
    inv_d = half_diff(diff);
    fwd_h = clamp_h(sum);
    // |x-y| always fits in W bits, so the low W bits negate exactly.
    fwd_m = clamp_mag(diff[W] ? ({W{1'b0}} - diff[W-1:0]) : diff[W-1:0]);
    if (mode_p1) begin
      x_c   = fwd_h[W-1:0];
      y_c   = {diff[W], fwd_m[W-2:0]};
      ovf_c = fwd_h[W] | fwd_m[W-1];
    end else if (b_p1[W-1]) begin
      x_c   = inv_d[W-1:0];
      y_c   = inv_s[W-1:0];
      ovf_c = inv_s[W] | inv_d[W];
    end else begin
      x_c   = inv_s[W-1:0];
      y_c   = inv_d[W-1:0];
      ovf_c = inv_s[W] | inv_d[W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      x_p2    <= '0;
      y_p2    <= '0;
      last_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      if (s1_adv) vld_p1 <= bus.in_valid;
      if (s2_adv) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          x_p2    <= x_c;
          y_p2    <= y_c;
          last_p2 <= last_p1;
          ovf_p2  <= ovf_c;
        end
      end
      // ---- S2 -> output: frame counter and sticky overflow ----
      if (out_fire) cnt <= last_p2 ? '0 : cnt + 1'b1;
      if (out_fire && ovf_p2) ovf <= 1'b1;
      else if (ovf_clr)       ovf <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_x     = x_p2;
  assign bus.out_y     = y_p2;
  assign bus.out_last  = last_p2;
  assign bus.out_count = cnt;

endmodule

// File: tb/tb_haar_lift_stage.sv
// -----------------------------------------------------------------------------
// tb_haar_lift_stage
// Directed bench for haar_lift_stage. Two instances (SAT=0 and SAT=1) receive
// identical stimulus; each scenario task checks both against hand-computed
// results.
// -----------------------------------------------------------------------------
module tb_haar_lift_stage;
  localparam int W     = 16;
  localparam int CNT_W = 12;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic         mode      = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_last   = 1'b0;
  logic         out_ready = 1'b1;
  logic         ovf_clr   = 1'b0;
  logic [W-1:0] in_a      = '0;
  logic [W-1:0] in_b      = '0;
  logic         ovf0, ovf1;
  logic [45:0]  obs0, obs1;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  haar_lift_stage_if #(.W(W), .CNT_W(CNT_W)) if0 ();
  haar_lift_stage_if #(.W(W), .CNT_W(CNT_W)) if1 ();

  assign if0.mode = mode;      assign if1.mode = mode;
  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_a = in_a;      assign if1.in_a = in_a;
  assign if0.in_b = in_b;      assign if1.in_b = in_b;
  assign if0.in_last = in_last;   assign if1.in_last = in_last;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  haar_lift_stage #(.W(W), .SAT(1'b0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .reset(reset), .bus(if0), .ovf(ovf0), .ovf_clr(ovf_clr)
  );
  haar_lift_stage #(.W(W), .SAT(1'b1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .reset(reset), .bus(if1), .ovf(ovf1), .ovf_clr(ovf_clr)
  );

  // {out_valid, out_x, out_y, out_last, out_count}
  assign obs0 = {if0.out_valid, if0.out_x, if0.out_y, if0.out_last, if0.out_count};
  assign obs1 = {if1.out_valid, if1.out_x, if1.out_y, if1.out_last, if1.out_count};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic last);
    mode = m; in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({obs0, ovf0, obs1, ovf1} !== 94'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h / %h want 0", {obs0, ovf0}, {obs1, ovf1});
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({if0.in_ready, if1.in_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 11", {if0.in_ready, if1.in_ready});
    end
  endtask

  task automatic test_inverse();
    logic [45:0] e;
    drive(1'b0, 16'd100, 16'h8014, 1'b0);
    tick();
    n_cmp++;
    if ({if0.out_valid, if1.out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL inv_latency: got %b want 00", {if0.out_valid, if1.out_valid});
    end
    drive(1'b0, 16'd100, 16'h0014, 1'b1);
    tick();
    e = {1'b1, 16'd40, 16'd60, 1'b0, 12'd0};
    n_cmp++;
    if ({obs0, obs1} !== {e, e}) begin
      n_err++;
      $display("FAIL inv_neg_detail: got %h / %h want %h", obs0, obs1, e);
    end
    idle();
    tick();
    e = {1'b1, 16'd60, 16'd40, 1'b1, 12'd1};
    n_cmp++;
    if ({obs0, obs1, ovf0, ovf1} !== {e, e, 2'b00}) begin
      n_err++;
      $display("FAIL inv_pos_detail: got %h / %h ovf %b%b want %h ovf 00", obs0, obs1, ovf0, ovf1, e);
    end
    tick();
    n_cmp++;
    if ({if0.out_valid, if0.out_count, if1.out_valid, if1.out_count} !== 26'd0) begin
      n_err++;
      $display("FAIL inv_drain: got %b %0d / %b %0d want 0 0", if0.out_valid, if0.out_count,
               if1.out_valid, if1.out_count);
    end
  endtask

  task automatic test_forward();
    logic [45:0] e;
    drive(1'b1, 16'd60, 16'd40, 1'b0);
    tick();
    drive(1'b1, 16'd40, 16'd60, 1'b0);
    tick();
    e = {1'b1, 16'd100, 16'h0014, 1'b0, 12'd0};
    n_cmp++;
    if ({obs0, obs1} !== {e, e}) begin
      n_err++;
      $display("FAIL fwd_x_gt_y: got %h / %h want %h", obs0, obs1, e);
    end
    drive(1'b0, 16'd100, 16'h0014, 1'b0);
    tick();
    e = {1'b1, 16'd100, 16'h8014, 1'b0, 12'd1};
    n_cmp++;
    if ({obs0, obs1} !== {e, e}) begin
      n_err++;
      $display("FAIL fwd_x_lt_y: got %h / %h want %h", obs0, obs1, e);
    end
    drive(1'b0, 16'd100, 16'h8014, 1'b1);
    tick();
    e = {1'b1, 16'd60, 16'd40, 1'b0, 12'd2};
    n_cmp++;
    if ({obs0, obs1} !== {e, e}) begin
      n_err++;
      $display("FAIL roundtrip_1: got %h / %h want %h", obs0, obs1, e);
    end
    idle();
    tick();
    e = {1'b1, 16'd40, 16'd60, 1'b1, 12'd3};
    n_cmp++;
    if ({obs0, obs1, ovf0, ovf1} !== {e, e, 2'b00}) begin
      n_err++;
      $display("FAIL roundtrip_2: got %h / %h ovf %b%b want %h ovf 00", obs0, obs1, ovf0, ovf1, e);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [45:0] e0, e1;
    drive(1'b0, 16'd10, 16'h0014, 1'b1);
    tick();
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b1);
    tick();
    e0 = {1'b1, 16'd15, 16'h7FFB, 1'b1, 12'd0};
    e1 = {1'b1, 16'd15, 16'h0000, 1'b1, 12'd0};
    n_cmp++;
    if ({obs0, obs1, ovf0, ovf1} !== {e0, e1, 2'b00}) begin
      n_err++;
      $display("FAIL inv_borrow: got %h / %h ovf %b%b want %h / %h ovf 00", obs0, obs1, ovf0, ovf1, e0, e1);
    end
    idle();
    tick();
    e0 = {1'b1, 16'h0000, 16'h7FFE, 1'b1, 12'd0};
    e1 = {1'b1, 16'hFFFF, 16'h7FFF, 1'b1, 12'd0};
    n_cmp++;
    if ({obs0, obs1, ovf0, ovf1} !== {e0, e1, 2'b11}) begin
      n_err++;
      $display("FAIL fwd_carry: got %h / %h ovf %b%b want %h / %h ovf 11", obs0, obs1, ovf0, ovf1, e0, e1);
    end
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++;
    if ({ovf0, ovf1} !== 2'b00) begin
      n_err++;
      $display("FAIL ovf_clear: got %b%b want 00", ovf0, ovf1);
    end
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b1);
    tick();
    idle();
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++;
    if ({ovf0, ovf1} !== 2'b11) begin
      n_err++;
      $display("FAIL ovf_set_wins: got %b%b want 11", ovf0, ovf1);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ex [6];
    logic [W-1:0] ey [6];
    logic [45:0]  e, held;
    logic         hold_chk;
    int           sent, got, stall_in;
    ex = '{16'd101, 16'd107, 16'd113, 16'd119, 16'd125, 16'd131};
    ey = '{16'd99, 16'd103, 16'd107, 16'd111, 16'd115, 16'd119};
    sent = 0; got = 0; stall_in = 0; hold_chk = 1'b0; held = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 6) drive(1'b0, 16'(200 + 10 * sent), 16'(2 * sent + 2), sent == 5);
      else idle();
      #1;
      if (hold_chk) begin
        n_cmp++;
        if ({obs0, obs1} !== {held, held}) begin
          n_err++;
          $display("FAIL stall_hold: got %h / %h want %h", obs0, obs1, held);
        end
      end
      hold_chk = 1'b0;
      if (!if0.in_ready) stall_in++;
      if (if0.out_valid) begin
        e = {1'b1, ex[got], ey[got], got == 5, 12'(got)};
        n_cmp++;
        if ({obs0, obs1} !== {e, e}) begin
          n_err++;
          $display("FAIL stream_beat%0d: got %h / %h want %h", got, obs0, obs1, e);
        end
        if (!out_ready) begin
          held = obs0;
          hold_chk = 1'b1;
        end else begin
          got++;
        end
      end
      if (in_valid && if0.in_ready) sent++;
      @(posedge clk);
      #1;
    end
    idle();
    out_ready = 1'b1;
    n_cmp++;
    if (got != 6 || sent != 6) begin
      n_err++;
      $display("FAIL stream_count: got %0d out / %0d in want 6 / 6", got, sent);
    end
    n_cmp++;
    if (stall_in != 3) begin
      n_err++;
      $display("FAIL in_ready_stall: got %0d low cycles want 3", stall_in);
    end
    n_cmp++;
    if ({if0.out_valid, if1.out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL stream_no_dup: got %b want 00", {if0.out_valid, if1.out_valid});
    end
  endtask

  task automatic test_framing();
    logic [11:0] ecnt [5];
    logic [45:0] e;
    ecnt = '{12'd0, 12'd1, 12'd2, 12'd0, 12'd1};
    for (int c = 0; c < 7; c++) begin
      if (c < 5) drive(1'b0, 16'(8 + 4 * c), 16'd0, c == 2);
      else idle();
      tick();
      if (c >= 1 && c <= 5) begin
        e = {1'b1, 16'(4 + 2 * (c - 1)), 16'(4 + 2 * (c - 1)), (c - 1) == 2, ecnt[c-1]};
        n_cmp++;
        if ({obs0, obs1} !== {e, e}) begin
          n_err++;
          $display("FAIL frame_beat%0d: got %h / %h want %h", c - 1, obs0, obs1, e);
        end
      end else if (c == 6) begin
        n_cmp++;
        if ({if0.out_valid, if0.out_count, if1.out_valid, if1.out_count} !== {1'b0, 12'd2, 1'b0, 12'd2}) begin
          n_err++;
          $display("FAIL frame_end: got %b %0d / %b %0d want 0 2", if0.out_valid, if0.out_count,
                   if1.out_valid, if1.out_count);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [45:0] e;
    drive(1'b0, 16'd100, 16'h8014, 1'b0);
    tick();
    drive(1'b0, 16'd100, 16'h0014, 1'b0);
    tick();
    idle();
    e = {1'b1, 16'd40, 16'd60, 1'b0, 12'd2};
    n_cmp++;
    if ({obs0, obs1} !== {e, e}) begin
      n_err++;
      $display("FAIL pre_reset: got %h / %h want %h", obs0, obs1, e);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({obs0, obs1} !== 92'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h / %h want 0", obs0, obs1);
    end
    #2;
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({if0.in_ready, if1.in_ready, if0.out_valid, if1.out_valid} !== 4'b1100) begin
      n_err++;
      $display("FAIL post_reset: got %b want 1100", {if0.in_ready, if1.in_ready, if0.out_valid, if1.out_valid});
    end
    drive(1'b0, 16'd100, 16'h0014, 1'b1);
    tick();
    idle();
    tick();
    e = {1'b1, 16'd60, 16'd40, 1'b1, 12'd0};
    n_cmp++;
    if ({obs0, obs1} !== {e, e}) begin
      n_err++;
      $display("FAIL resume_beat: got %h / %h want %h", obs0, obs1, e);
    end
    tick();
    n_cmp++;
    if ({if0.out_valid, if1.out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL resume_drain: got %b want 00", {if0.out_valid, if1.out_valid});
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_inverse();
    test_forward();
    test_overflow();
    test_back_to_back();
    test_framing();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/haar_lift_stage.md
Name: haar_lift_stage

Overview:
Parametrised, bidirectional Haar lifting stage for the wavelet datapath. In inverse mode it reconstructs a pixel pair from an approximation word and a sign-magnitude detail word. In forward mode it produces that approximation/detail pair from a pixel pair. It is a 2-stage pipeline with valid/ready flow control, selectable saturation, a per-frame sample counter and a sticky overflow flag.

Parameters:
W, 16, data width of all sample buses (W >= 4)
SAT, 0, 0 = modulo-2^W arithmetic (bit-compatible with existing inverse stage); 1 = exact W+1-bit arithmetic with clamping
CNT_W, 12, width of per-frame sample counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
mode  in  1  sampled with each input beat: 0 = inverse, 1 = forward
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept a beat
in_a  in  W  inverse: approximation h (unsigned); forward: pixel x (unsigned)
in_b  in  W  inverse: detail, MSB = sign, [W-2:0] = magnitude; forward: pixel y (unsigned)
in_last  in  1  last beat of frame
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_x  out  W  inverse: pixel x; forward: h
out_y  out  W  inverse: pixel y; forward: sign-magnitude detail
out_last  out  1  in_last delayed with its beat
out_count  out  CNT_W  index of current output beat within frame
ovf  out  1  sticky: a wrap or clamp occurred
ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (async, reset=0): all pipeline valids=0, out_x=out_y=0, out_last=0, out_count=0, ovf=0. in_ready is 1 from the first edge after reset deasserts. Reset mid-stream discards in-flight beats.
- Transfer rule: a beat moves on a port when valid&ready are both high at a rising edge. out_* hold stable while out_valid=1 and out_ready=0.
- Pipeline:
  - S1 registers in_a, in_b, mode and in_last.
  - S2 registers the computed result.
  - Latency is 2 cycles with no stall. Throughput is 1 beat/cycle.
  - s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv. This is a combinational ready chain.
  - No beat is dropped or duplicated under any stall pattern.
- Inverse arithmetic, with m = {0, in_b[W-2:0]} and s = in_b[W-1]:
  - s=0: x = h+m, y = h-m.
  - s=1: x = h-m, y = h+m.
  - Both results are then shifted right by 1.
  - SAT=0: sums and differences are W-bit modulo, then a logical shift. ovf is set if h+m carries or h-m borrows.
  - SAT=1: computed in W+1 bits. A negative difference clamps to 0 and sets ovf. The shifted sum always fits in W bits.
- Forward arithmetic, with x = in_a and y = in_b:
  - h = x+y. SAT=0: W-bit wrap. SAT=1: clamp to 2^W-1. Either case sets ovf when it occurs.
  - Detail sign = (x<y); magnitude = |x-y|.
  - If |x-y| > 2^(W-1)-1: SAT=0 truncates to W-1 bits, SAT=1 clamps to 2^(W-1)-1. Either case sets ovf.
  - Round trip forward then inverse is exact whenever x,y < 2^(W-1).
- Mode switching: mode travels with each beat, so consecutive beats may alternate modes with no bubble.
- out_count:
  - Increments on each output transfer.
  - Returns to 0 on the transfer after one carrying out_last=1.
  - Wraps modulo 2^CNT_W within a frame.
- ovf:
  - Set when an S2 result that raised overflow is transferred out.
  - ovf_clr clears it.
  - Simultaneous set and clear: set wins.

Test Plan:
1. Inverse, W=16: h=100, b=0x8014 -> x=40, y=60. Then h=100, b=0x0014 -> x=60, y=40. Both at 2-cycle latency, out_count 0 then 1, ovf=0.
2. Forward: x=60, y=40 -> out_x=100, out_y=0x0014. Then x=40, y=60 -> out_x=100, out_y=0x8014. Feeding both outputs back in inverse mode returns the original pairs.
3. Overflow on inverse h=10, b=0x0014:
   - SAT=1: y=0, ovf=1.
   - SAT=0: y=0xFFF6>>1=0x7FFB, ovf=1.
   - ovf_clr pulse -> ovf=0. ovf_clr coincident with a new overflow beat -> ovf stays 1.
4. Backpressure: stream 6 beats, out_ready low for cycles 3-5.
   - in_ready falls once S1 and S2 are both full.
   - Outputs stay held while stalled.
   - All 6 results arrive in order with no duplicates.
5. Framing: 3 beats with in_last on the third, then 2 more beats -> out_count 0,1,2,0,1; out_last=1 only on the third output.
6. Async reset asserted mid-cycle with 2 beats in flight -> out_valid=0 and out_count=0 immediately without a clock edge; stream resumes cleanly after release.
